// File: rtl/n_demux2_pkg.sv
// ---------------------------------------------------------------------------
// n_demux2_pkg
// Shared definitions for the registered 1-to-2 stream demultiplexer.
//   SEL_OUT0 / SEL_OUT1 : in_sel values that steer a word to out0 / out1
//   slice_state_t       : per-output register slice state (EMPTY / FULL)
//   COUNT_WIDTH         : width of the optional per-port transfer counters
// ---------------------------------------------------------------------------
package n_demux2_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  localparam int COUNT_WIDTH = 16;

  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_t;

endpackage : n_demux2_pkg

// File: rtl/n_reg_slice.sv
// ---------------------------------------------------------------------------
// n_reg_slice
// One-entry register slice feeding a single consumer of the demux.
// Optional feature: macro N_DEMUX2_COUNT_EN adds a wrapping transfer counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   load      in   accepted input word is destined for this slice
//   data_in   in   payload to capture on load
//   valid     out  slice holds a word
//   ready     in   consumer accepts the held word
//   data_out  out  held payload (stable while FULL, retained while EMPTY)
//   count     out  output transfers seen (only with N_DEMUX2_COUNT_EN)
// ---------------------------------------------------------------------------
module n_reg_slice
  import n_demux2_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   valid,
  input  logic                   ready,
  output logic [DATA_WIDTH-1:0]  data_out
`ifdef N_DEMUX2_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] count
`endif
);

  slice_state_t          state_q;
  slice_state_t          state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  out_xfer;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLICE_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs. A load only happens when the slice is EMPTY or
  // being drained this cycle, so a load always leaves the slice FULL.
  always_comb begin
    state_d  = state_q;
    valid    = (state_q == SLICE_FULL);
    out_xfer = valid & ready;
    unique case (state_q)
      SLICE_EMPTY: begin
        if (load) state_d = SLICE_FULL;
      end
      SLICE_FULL: begin
        if (out_xfer && !load) state_d = SLICE_EMPTY;
      end
      default: state_d = SLICE_EMPTY;
    endcase
  end

  // Payload register: written only on a load, held otherwise (even when EMPTY).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;

`ifdef N_DEMUX2_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  // Natural binary wrap from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (out_xfer) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
`endif

endmodule : n_reg_slice

// File: rtl/n_demux2_reg.sv
// ---------------------------------------------------------------------------
// n_demux2_reg
// Registered 1-to-2 stream demultiplexer with valid/ready handshakes. Each
// output owns a one-entry register slice so a stalled consumer only blocks
// words addressed to it.
// Optional feature: macro N_DEMUX2_COUNT_EN adds out0_count / out1_count.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data  producer stream
//   in_sel                     destination (0 -> out0, 1 -> out1)
//   outN_valid/outN_ready      consumer N handshake
//   outN_data                  consumer N payload
//   outN_count                 transfers on port N (N_DEMUX2_COUNT_EN only)
// ---------------------------------------------------------------------------
module n_demux2_reg
  import n_demux2_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_sel,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [DATA_WIDTH-1:0]  out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [DATA_WIDTH-1:0]  out1_data
`ifdef N_DEMUX2_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out0_count,
  output logic [COUNT_WIDTH-1:0] out1_count
`endif
);

  logic [1:0]            slice_valid;
  logic [1:0]            slice_ready;
  logic [1:0]            slice_load;
  logic [DATA_WIDTH-1:0] slice_data [2];
`ifdef N_DEMUX2_COUNT_EN
  logic [COUNT_WIDTH-1:0] slice_count [2];
`endif

  assign slice_ready = {out1_ready, out0_ready};

  // Acceptance depends only on the addressed slice, never on in_valid, so
  // there is no combinational path from in_valid/in_data to any output.
  assign in_ready = (in_sel == SEL_OUT1) ? (~slice_valid[1] | slice_ready[1])
                                         : (~slice_valid[0] | slice_ready[0]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      localparam logic SEL_N = (gi == 0) ? SEL_OUT0 : SEL_OUT1;

      // in_valid gates the load first so that in_sel/in_data are ignored
      // while no word is offered.
      assign slice_load[gi] = in_valid & in_ready & (in_sel == SEL_N);

      n_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slice (
        .clk      (clk),
        .reset    (reset),
        .load     (slice_load[gi]),
        .data_in  (in_data),
        .valid    (slice_valid[gi]),
        .ready    (slice_ready[gi]),
        .data_out (slice_data[gi])
`ifdef N_DEMUX2_COUNT_EN
        ,
        .count    (slice_count[gi])
`endif
      );
    end
  endgenerate

  assign out0_valid = slice_valid[0];
  assign out1_valid = slice_valid[1];
  assign out0_data  = slice_data[0];
  assign out1_data  = slice_data[1];
`ifdef N_DEMUX2_COUNT_EN
  assign out0_count = slice_count[0];
  assign out1_count = slice_count[1];
`endif

endmodule : n_demux2_reg

// File: tb/tb_n_demux2_reg.sv
// ---------------------------------------------------------------------------
// tb_n_demux2_reg
// Directed self-checking bench for n_demux2_reg (DATA_WIDTH = 8). The count
// tests are compiled only when N_DEMUX2_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_n_demux2_reg;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;
`ifdef N_DEMUX2_COUNT_EN
  logic [15:0]   out0_count;
  logic [15:0]   out1_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n_demux2_reg #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef N_DEMUX2_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance past one rising edge; inputs are driven 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after a drive.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  initial begin
    reset      = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // ---- reset / idle ----
    settle();
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data",  32'(out0_data),  32'h00);
    chk("rst_out1_data",  32'(out1_data),  32'h00);
    chk("rst_in_ready_s0", 32'(in_ready),  32'd1);
    in_sel = 1'b1;
    settle();
    chk("rst_in_ready_s1", 32'(in_ready),  32'd1);
`ifdef N_DEMUX2_COUNT_EN
    chk("rst_out0_count", 32'(out0_count), 32'd0);
    chk("rst_out1_count", 32'(out1_count), 32'd0);
`endif

    // ---- basic steering, both consumers ready ----
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    drive(1'b1, 8'hA5, 1'b0);
    settle();
    chk("a5_in_ready", 32'(in_ready), 32'd1);
    step();                               // 0xA5 accepted
    drive(1'b1, 8'h3C, 1'b1);
    settle();
    chk("a5_out0_valid", 32'(out0_valid), 32'd1);
    chk("a5_out0_data",  32'(out0_data),  32'hA5);
    chk("a5_out1_valid", 32'(out1_valid), 32'd0);
    chk("3c_in_ready",   32'(in_ready),   32'd1);
    step();                               // 0xA5 consumed, 0x3C accepted
    drive(1'b0, 8'h00, 1'b0);
    settle();
    chk("3c_out0_valid", 32'(out0_valid), 32'd0);
    chk("3c_out1_valid", 32'(out1_valid), 32'd1);
    chk("3c_out1_data",  32'(out1_data),  32'h3C);
    step();                               // 0x3C consumed
    settle();
    chk("idle_out1_valid", 32'(out1_valid), 32'd0);
    chk("hold_out0_data",  32'(out0_data),  32'hA5);

    // ---- backpressure on out0 ----
    out0_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    step();                               // 0x11 accepted
    drive(1'b1, 8'h22, 1'b0);
    settle();
    chk("bp_in_ready_22", 32'(in_ready),   32'd0);
    chk("bp_out0_valid",  32'(out0_valid), 32'd1);
    chk("bp_out0_data",   32'(out0_data),  32'h11);
    step();                               // 0x22 refused
    settle();
    chk("bp_out0_keep",   32'(out0_data),  32'h11);
    chk("bp_out1_empty",  32'(out1_valid), 32'd0);
    drive(1'b1, 8'h33, 1'b1);
    settle();
    chk("bp_in_ready_33", 32'(in_ready),   32'd1);
    step();                               // 0x33 accepted to out1
    drive(1'b0, 8'h00, 1'b0);
    settle();
    chk("bp_out1_valid",  32'(out1_valid), 32'd1);
    chk("bp_out1_data",   32'(out1_data),  32'h33);
    chk("bp_out0_still",  32'(out0_data),  32'h11);
    chk("bp_out0_vstill", 32'(out0_valid), 32'd1);
    out0_ready = 1'b1;
    step();                               // both drained
    settle();
    chk("drain_out0_valid", 32'(out0_valid), 32'd0);
    chk("drain_out1_valid", 32'(out1_valid), 32'd0);

    // ---- streaming 0x00..0x07 to out0 ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      settle();
      chk($sformatf("st_in_ready_%0d", i), 32'(in_ready), 32'd1);
      step();
      settle();
      chk($sformatf("st_out0_valid_%0d", i), 32'(out0_valid), 32'd1);
      chk($sformatf("st_out0_data_%0d", i),  32'(out0_data),  32'(i));
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    settle();
    chk("st_out0_done", 32'(out0_valid), 32'd0);

    // ---- reset while both slices FULL ----
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 8'h55, 1'b0);
    step();
    drive(1'b1, 8'hAA, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    settle();
    chk("full_out0_data", 32'(out0_data), 32'h55);
    chk("full_out1_data", 32'(out1_data), 32'hAA);
    out0_ready = 1'b1;                    // a transfer presented during reset
    drive(1'b1, 8'h77, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    out0_ready = 1'b0;
    settle();
    chk("mrst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mrst_out1_valid", 32'(out1_valid), 32'd0);
    chk("mrst_in_ready",   32'(in_ready),   32'd1);
    chk("mrst_out1_data",  32'(out1_data),  32'h00);

`ifdef N_DEMUX2_COUNT_EN
    // ---- counter wrap on out1 ----
    chk("cnt_start_out1", 32'(out1_count), 32'd0);
    out1_ready = 1'b1;
    drive(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 65534; i++) step();
    drive(1'b0, 8'h00, 1'b0);
    step();                               // last of 65534 words consumed
    settle();
    chk("cnt_out1_fffe", 32'(out1_count), 32'hFFFE);
    drive(1'b1, 8'h01, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    settle();
    chk("cnt_out1_ffff", 32'(out1_count), 32'hFFFF);
    drive(1'b1, 8'h02, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    settle();
    chk("cnt_out1_wrap", 32'(out1_count), 32'h0000);
    chk("cnt_out0_zero", 32'(out0_count), 32'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_n_demux2_reg

// File: doc/n_demux2_reg.md
# n_demux2_reg

Registered, parameterized 1-to-2 stream demultiplexer with valid/ready handshakes. It is the distributing counterpart of the 2-input select mux: a single producer stream, such as the data-memory request path of the MIPS datapath, is steered to one of two consumers, such as RAM or memory-mapped I/O. Each output has its own one-entry register slice, so a stall on one consumer does not block traffic bound for the other.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the data payload.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  demux accepts the word this cycle
- in_data  in  DATA_WIDTH  payload
- in_sel  in  1  destination: 0 selects out0, 1 selects out1
- out0_valid  out  1  slice 0 holds a word
- out0_ready  in  1  consumer 0 accepts
- out0_data  out  DATA_WIDTH  slice 0 payload
- out1_valid  out  1  slice 1 holds a word
- out1_ready  in  1  consumer 1 accepts
- out1_data  out  DATA_WIDTH  slice 1 payload

## Operation
- Input transfer: in_valid & in_ready at a rising edge.
- Output transfer: outN_valid & outN_ready at a rising edge.
- Per-slice state machine, slice N:
  - EMPTY: outN_valid=0.
  - EMPTY to FULL on an input transfer with in_sel=N.
  - FULL: outN_valid=1, outN_data stable.
  - FULL to EMPTY on an output transfer with no new input for slice N.
  - FULL stays FULL on a simultaneous output transfer and input transfer to N. The data register loads the new word.
- in_ready = ~outSEL_valid | outSEL_ready, where SEL = in_sel.
  - Combinational from in_sel, outN_valid and outN_ready.
  - Independent of in_valid.
- Full throughput: one word per cycle per slice while the consumer holds ready high.
- The non-selected slice is never modified by an input transfer.
- No ordering between out0 and out1 is guaranteed. Order within each output is preserved.
- outN_data is loaded only on an input transfer to N. It holds its value otherwise, including while EMPTY.
- in_sel and in_data are sampled only when in_valid=1. X on them while in_valid=0 must not propagate to state.

## Timing
- Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0. in_ready is 1 after reset, because both slices are EMPTY.
- Reset mid-operation: held words are discarded and both slices return to EMPTY on the next edge. Any transfer presented in that cycle is dropped.
- Latency: a word accepted at edge k is visible on outN_valid/outN_data after edge k, so it can be consumed at edge k+1.
- Backpressure: slice N FULL with outN_ready=0 and in_sel=N gives in_ready=0. A word with in_sel pointing at the other, non-full slice is still accepted in the same cycle.
- Handshake rules:
  - The producer must hold in_valid, in_data and in_sel stable until accepted.
  - The demux holds outN_valid and outN_data stable until consumed.
- No combinational path from in_valid or in_data to any output.

## Configuration
- Macro N_DEMUX2_COUNT_EN.
- Defined:
  - Adds output ports out0_count and out1_count, 16 bits each.
  - Each counts output transfers on its port and wraps from 0xFFFF to 0x0000.
  - Both reset to 0.
  - A count increments in the same cycle as its transfer edge.
- Undefined:
  - The count ports and counter logic are absent.
  - The rest of the behaviour is identical.

## Structure
- Package n_demux2_pkg:
  - Constants SEL_OUT0=1'b0 and SEL_OUT1=1'b1.
  - Slice state encoding SLICE_EMPTY and SLICE_FULL.
  - COUNT_WIDTH=16.
- Sub-module n_reg_slice, instantiated twice:
  - DATA_WIDTH parameter.
  - Ports load, data_in, valid, ready, data_out.
  - Contains the per-slice state machine and the optional counter.
- Top level holds only the in_ready select and the load steering.

## Test plan
- Reset, then idle: out0_valid=0, out1_valid=0, in_ready=1, data outputs 0.
- Send 0xA5 with sel=0, then 0x3C with sel=1, both consumers ready: out0 shows 0xA5 one cycle after acceptance and out1 shows 0x3C one cycle later. Neither slice shows a spurious valid.
- Stall on out0: out0_ready=0, send 0x11 with sel=0, then 0x22 with sel=0. The first is accepted and in_ready=0 for the second. Present 0x33 with sel=1: it is accepted and appears on out1 while out0 still holds 0x11.
- Streaming: out0_ready=1 held, 8 back-to-back words 0x00..0x07 with sel=0. in_ready stays 1 and out0 delivers 0x00..0x07 in order, one per cycle.
- Reset asserted for one cycle while both slices are FULL (0x55, 0xAA): both valids are 0 after the edge and in_ready=1.
- With N_DEMUX2_COUNT_EN defined:
  - Preload out1_count to 0xFFFE by 65534 transfers.
  - Two more transfers give 0xFFFF then 0x0000.
  - out0_count is unaffected.
